// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared widths, FSM state and owner encodings for the memory port arbiter
package mem_arb_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
  typedef enum logic {INSTR, DATA} owner_e;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, LSU and shared memory port signals of the arbiter
interface mem_port_arbiter_if;
  import mem_arb_pkg::*;
  logic              instr_req_i;
  logic [ADDR_W-1:0] instr_addr_i;
  logic              instr_gnt_o;
  logic              instr_rvalid_o;
  logic [DATA_W-1:0] instr_rdata_o;
  logic              instr_err_o;
  logic              data_req_i;
  logic              data_we_i;
  logic [BE_W-1:0]   data_be_i;
  logic [ADDR_W-1:0] data_addr_i;
  logic [DATA_W-1:0] data_wdata_i;
  logic              data_gnt_o;
  logic              data_rvalid_o;
  logic [DATA_W-1:0] data_rdata_o;
  logic              data_err_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [BE_W-1:0]   mem_be_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic              mem_err_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              busy_o;
  modport slave (
    input  instr_req_i, instr_addr_i, data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
           mem_gnt_i, mem_rvalid_i, mem_err_i, mem_rdata_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
           data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
           mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, busy_o
  );
  modport master (
    output instr_req_i, instr_addr_i, data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
           mem_gnt_i, mem_rvalid_i, mem_err_i, mem_rdata_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
           data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
           mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, busy_o
  );
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner selection; data wins ties unless instr is preferred
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_instr_req,
  input  logic   i_data_req,
  input  logic   i_pref_instr,
  output logic   o_any,
  output owner_e o_win
);
  always_comb begin
    o_any = i_instr_req | i_data_req;
    o_win = (i_instr_req && (!i_data_req || i_pref_instr)) ? INSTR : DATA;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and LSU, one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin ties; otherwise fixed priority with starvation limit.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input logic           CLK,
  input logic           RST_N,
  mem_port_arbiter_if.slave bus
);
  state_e            r_state, w_state_nxt;
  owner_e            r_owner, w_win;
  logic              r_we;
  logic [BE_W-1:0]   r_be;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              w_any, w_arb, w_pref_instr, w_req, w_resp, w_i;

  mem_arb_pick u_pick (
    .i_instr_req (bus.instr_req_i),
    .i_data_req  (bus.data_req_i),
    .i_pref_instr(w_pref_instr),
    .o_any       (w_any),
    .o_win       (w_win)
  );

`ifdef MEM_ARB_RR_EN
  owner_e r_last;
  assign w_pref_instr = r_last == DATA;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) r_last <= INSTR;
    else if (w_arb) r_last <= w_win;
`else
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] r_starve;
  assign w_pref_instr = r_starve == CW'(STARVE_LIMIT);
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) r_starve <= '0;
    else if (w_arb)
      r_starve <= w_win == INSTR ? '0 : (bus.instr_req_i && !w_pref_instr) ? r_starve + 1'b1 : r_starve;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_arb       = 1'b0;
    case (r_state)
      IDLE: begin
        w_arb       = w_any;
        w_state_nxt = w_any ? REQ : IDLE;
      end
      REQ:  w_state_nxt = bus.mem_gnt_i ? RESP : REQ;
      RESP: begin
        w_arb       = bus.mem_rvalid_i && w_any;
        w_state_nxt = !bus.mem_rvalid_i ? RESP : w_any ? REQ : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // request fields are captured at arbitration so they hold steady until the grant
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      r_state <= IDLE;
      r_owner <= INSTR;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_arb) begin
        r_owner <= w_win;
        r_we    <= w_win == DATA && bus.data_we_i;
        r_be    <= w_win == DATA ? bus.data_be_i : '1;
        r_addr  <= w_win == DATA ? bus.data_addr_i : bus.instr_addr_i;
        r_wdata <= w_win == DATA ? bus.data_wdata_i : '0;
      end
    end

  assign w_req  = r_state == REQ;
  assign w_resp = r_state == RESP;
  assign w_i    = r_owner == INSTR;

  assign bus.mem_req_o      = w_req;
  assign bus.mem_we_o       = w_req & r_we;
  assign bus.mem_be_o       = w_req ? r_be : '0;
  assign bus.mem_addr_o     = w_req ? r_addr : '0;
  assign bus.mem_wdata_o    = w_req ? r_wdata : '0;
  assign bus.instr_gnt_o    = w_req & w_i & bus.mem_gnt_i;
  assign bus.data_gnt_o     = w_req & !w_i & bus.mem_gnt_i;
  assign bus.instr_rvalid_o = w_resp & w_i & bus.mem_rvalid_i;
  assign bus.data_rvalid_o  = w_resp & !w_i & bus.mem_rvalid_i;
  assign bus.instr_err_o    = w_resp & w_i & bus.mem_err_i;
  assign bus.data_err_o     = w_resp & !w_i & bus.mem_err_i;
  assign bus.instr_rdata_o  = (w_resp & w_i) ? bus.mem_rdata_i : '0;
  assign bus.data_rdata_o   = (w_resp & !w_i) ? bus.mem_rdata_i : '0;
  assign bus.busy_o         = r_state != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, handshakes, errors and reset abandonment
module tb_mem_port_arbiter;
  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [9:0] pat;

  mem_port_arbiter_if bus ();
  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (.CLK(clk), .RST_N(rst_n), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.instr_req_i = 0; bus.instr_addr_i = 0;
    bus.data_req_i = 0; bus.data_we_i = 0; bus.data_be_i = 0; bus.data_addr_i = 0; bus.data_wdata_i = 0;
    bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_err_i = 0; bus.mem_rdata_i = 0;
    tick(); tick();
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_mem_req", bus.mem_req_o, 0);
    chk("rst_mem_addr", bus.mem_addr_o, 0);
    chk("rst_igrant", bus.instr_gnt_o, 0);
    rst_n = 1'b1;
    tick();
    // instruction-only read
    bus.instr_req_i = 1; bus.instr_addr_i = 32'h0000_0100; #1;
    chk("i_idle_req", bus.mem_req_o, 0);
    tick();
    chk("i_mem_req", bus.mem_req_o, 1);
    chk("i_mem_addr", bus.mem_addr_o, 32'h100);
    chk("i_mem_be", bus.mem_be_o, 4'hF);
    chk("i_mem_we", bus.mem_we_o, 0);
    chk("i_gnt_wait", bus.instr_gnt_o, 0);
    tick();
    bus.mem_gnt_i = 1; #1;
    chk("i_gnt", bus.instr_gnt_o, 1);
    chk("i_dgnt", bus.data_gnt_o, 0);
    tick();
    bus.instr_req_i = 0; #1;
    chk("i_resp_gnt_ignored", bus.instr_gnt_o, 0);
    chk("i_resp_busy", bus.busy_o, 1);
    chk("i_rvalid_wait", bus.instr_rvalid_o, 0);
    bus.mem_gnt_i = 0;
    tick();
    bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h13; #1;
    chk("i_rvalid", bus.instr_rvalid_o, 1);
    chk("i_rdata", bus.instr_rdata_o, 32'h13);
    chk("i_d_rvalid", bus.data_rvalid_o, 0);
    chk("i_d_rdata", bus.data_rdata_o, 0);
    tick();
    bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0; #1;
    chk("i_done_busy", bus.busy_o, 0);
    // both requesting continuously, zero-wait memory
`ifdef MEM_ARB_RR_EN
    pat = 10'b10_1010_1010;
`else
    pat = 10'b10_0001_0000;
`endif
    bus.instr_req_i = 1; bus.instr_addr_i = 32'h0000_1000;
    bus.data_req_i = 1; bus.data_we_i = 0; bus.data_be_i = 4'hF; bus.data_addr_i = 32'h2000_0000;
    bus.mem_gnt_i = 1; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h55;
    tick();
    for (int k = 0; k < 10; k++) begin
      chk("seq_igrant", bus.instr_gnt_o, pat[k]);
      chk("seq_dgrant", bus.data_gnt_o, !pat[k]);
      chk("seq_addr", bus.mem_addr_o, pat[k] ? 32'h1000 : 32'h2000_0000);
      chk("seq_rvalid_in_req", bus.instr_rvalid_o | bus.data_rvalid_o, 0);
      if (k == 9) begin
        bus.instr_req_i = 0; bus.data_req_i = 0;
      end
      tick(); tick();
    end
    tick();
    bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0; #1;
    chk("seq_end_busy", bus.busy_o, 0);
    // data write with a 5-cycle grant stall; requester drops req meanwhile
    bus.data_req_i = 1; bus.data_we_i = 1; bus.data_be_i = 4'b0011;
    bus.data_addr_i = 32'h2000_0004; bus.data_wdata_i = 32'hDEAD_BEEF;
    tick();
    for (int c = 1; c <= 5; c++) begin
      if (c == 2) bus.data_req_i = 0;
      #1;
      chk("w_req", bus.mem_req_o, 1);
      chk("w_we", bus.mem_we_o, 1);
      chk("w_be", bus.mem_be_o, 4'b0011);
      chk("w_addr", bus.mem_addr_o, 32'h2000_0004);
      chk("w_wdata", bus.mem_wdata_o, 32'hDEAD_BEEF);
      chk("w_dgnt_stall", bus.data_gnt_o, 0);
      tick();
    end
    bus.mem_gnt_i = 1; #1;
    chk("w_dgnt", bus.data_gnt_o, 1);
    chk("w_igrant", bus.instr_gnt_o, 0);
    tick();
    bus.mem_gnt_i = 0; bus.data_we_i = 0; #1;
    chk("w_dgnt_after", bus.data_gnt_o, 0);
    bus.mem_rvalid_i = 1; #1;
    chk("w_rvalid", bus.data_rvalid_o, 1);
    tick();
    bus.mem_rvalid_i = 0; #1;
    chk("w_done_busy", bus.busy_o, 0);
    // data load returning an error, then a pending fetch back-to-back
    bus.data_req_i = 1; bus.data_addr_i = 32'h3000_0000; bus.data_be_i = 4'hF;
    tick();
    bus.mem_gnt_i = 1;
    tick();
    bus.mem_gnt_i = 0; bus.data_req_i = 0;
    bus.instr_req_i = 1; bus.instr_addr_i = 32'h0000_0200;
    bus.mem_rvalid_i = 1; bus.mem_err_i = 1; #1;
    chk("e_derr", bus.data_err_o, 1);
    chk("e_drvalid", bus.data_rvalid_o, 1);
    chk("e_ierr", bus.instr_err_o, 0);
    tick();
    bus.mem_rvalid_i = 0; bus.mem_err_i = 0; #1;
    chk("e_derr_clear", bus.data_err_o, 0);
    chk("e_b2b_req", bus.mem_req_o, 1);
    chk("e_b2b_addr", bus.mem_addr_o, 32'h200);
    bus.mem_gnt_i = 1; #1;
    chk("e_igrant", bus.instr_gnt_o, 1);
    tick();
    bus.mem_gnt_i = 0; bus.instr_req_i = 0;
    bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hABCD; #1;
    chk("e_irvalid", bus.instr_rvalid_o, 1);
    chk("e_irdata", bus.instr_rdata_o, 32'hABCD);
    chk("e_ierr_ok", bus.instr_err_o, 0);
    tick();
    bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0;
    // reset asserted while waiting for the response
    bus.instr_req_i = 1; bus.instr_addr_i = 32'h0000_0300;
    tick();
    bus.mem_gnt_i = 1;
    tick();
    bus.mem_gnt_i = 0; bus.instr_req_i = 0; #1;
    chk("r_in_resp", bus.busy_o, 1);
    rst_n = 1'b0; #1;
    chk("r_busy", bus.busy_o, 0);
    chk("r_mem_req", bus.mem_req_o, 0);
    bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h77; #1;
    chk("r_irvalid", bus.instr_rvalid_o, 0);
    chk("r_drvalid", bus.data_rvalid_o, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("r_irvalid_post", bus.instr_rvalid_o, 0);
    chk("r_irdata_post", bus.instr_rdata_o, 0);
    chk("r_busy_post", bus.busy_o, 0);
    bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
